qrisc32_bus_arbiter: RTL and testbench

QRISC32_BUS_ARBITER -- requirements
Module: qrisc32_bus_arbiter

---
 rtl/qrisc32_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_qrisc32_bus_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/qrisc32_bus_arbiter.sv
// Shares one Avalon-style slave between instruction-read, data-read and data-write
// masters. Fixed priority DW > DR > I, with the instruction master boosted once it has waited MAX_WAIT cycles.
module qrisc32_bus_arbiter #(
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_addr,
    input  logic        i_rd,
    output logic [31:0] i_rdata,
    output logic        i_wait_req,

    input  logic [31:0] dr_addr,
    input  logic        dr_rd,
    output logic [31:0] dr_rdata,
    output logic        dr_wait_req,

    input  logic [31:0] dw_addr,
    input  logic [31:0] dw_data,
    input  logic        dw_wr,
    output logic        dw_wait_req,

    output logic [31:0] s_addr,
    output logic        s_rd,
    output logic        s_wr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_wait_req,

    output logic [2:0]  grant
);
    // state | meaning
    // IDLE  | nothing granted; choose the next owner from pending requests
    // G_I   | instruction-read master owns the slave
    // G_DR  | data-read master owns the slave
    // G_DW  | data-write master owns the slave
    // The encodings are the one-hot grant vector, so grant comes straight from the state register.
    typedef enum logic [2:0] {
        IDLE = 3'b000,
        G_I  = 3'b001,
        G_DR = 3'b010,
        G_DW = 3'b100
    } state_t;

    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             granted_req;
    logic             i_done;

    always_comb begin
        granted_req = 1'b0;
        case (state)
            G_I:     granted_req = i_rd;
            G_DR:    granted_req = dr_rd;
            G_DW:    granted_req = dw_wr;
            default: granted_req = 1'b0;
        endcase
    end

    assign i_done = (state == G_I) && i_rd && !s_wait_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (starve_cnt == CNT_MAX && i_rd) state <= G_I;
                    else if (dw_wr)                   state <= G_DW;
                    else if (dr_rd)                   state <= G_DR;
                    else if (i_rd)                    state <= G_I;
                    else                              state <= IDLE;
                end
                // Leave on completion or when the owner withdraws its request.
                default: begin
                    if (!granted_req || !s_wait_req) state <= IDLE;
                end
            endcase

            if (!i_rd || i_done)
                starve_cnt <= '0;
            else if (state != G_I && starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign grant = state;

    // Slave port and wait_req steering follow the owner combinationally.
    always_comb begin
        s_addr      = '0;
        s_rd        = 1'b0;
        s_wr        = 1'b0;
        s_wdata     = '0;
        i_wait_req  = 1'b1;
        dr_wait_req = 1'b1;
        dw_wait_req = 1'b1;
        case (state)
            G_I: begin
                s_addr     = i_addr;
                s_rd       = i_rd;
                i_wait_req = s_wait_req;
            end
            G_DR: begin
                s_addr      = dr_addr;
                s_rd        = dr_rd;
                dr_wait_req = s_wait_req;
            end
            G_DW: begin
                s_addr      = dw_addr;
                s_wr        = dw_wr;
                s_wdata     = dw_data;
                dw_wait_req = s_wait_req;
            end
            default: ;
        endcase
    end

    assign i_rdata  = s_rdata;
    assign dr_rdata = s_rdata;

endmodule

// File: tb/tb_qrisc32_bus_arbiter.sv
// Directed bench for qrisc32_bus_arbiter: reset, single read, priority order,
// slave stall, request withdrawal, starvation boost and reset mid-grant.
module tb_qrisc32_bus_arbiter;
    logic        clk;
    logic        reset;
    logic [31:0] i_addr, dr_addr, dw_addr, dw_data, s_rdata;
    logic        i_rd, dr_rd, dw_wr, s_wait_req;
    logic [31:0] i_rdata, dr_rdata, s_addr, s_wdata;
    logic        i_wait_req, dr_wait_req, dw_wait_req, s_rd, s_wr;
    logic [2:0]  grant;

    int n_assert = 0;
    int n_fail   = 0;

    // Hand-derived traces for the priority and starvation scenarios.
    logic [2:0]  prio_grant [6] = '{3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    logic [31:0] prio_addr  [6] = '{32'h3000, 32'h0, 32'h300, 32'h0, 32'h104, 32'h0};
    logic [2:0]  stv_grant [10] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b100,
                                    3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    logic [31:0] stv_cnt   [10] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
                                    32'd6, 32'd7, 32'd8, 32'd8, 32'd0};

    qrisc32_bus_arbiter #(.MAX_WAIT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_addr      (i_addr),
        .i_rd        (i_rd),
        .i_rdata     (i_rdata),
        .i_wait_req  (i_wait_req),
        .dr_addr     (dr_addr),
        .dr_rd       (dr_rd),
        .dr_rdata    (dr_rdata),
        .dr_wait_req (dr_wait_req),
        .dw_addr     (dw_addr),
        .dw_data     (dw_data),
        .dw_wr       (dw_wr),
        .dw_wait_req (dw_wait_req),
        .s_addr      (s_addr),
        .s_rd        (s_rd),
        .s_wr        (s_wr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .s_wait_req  (s_wait_req),
        .grant       (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " grant"}, 32'(grant), 32'h0);
        check({tag, " s_rd"}, 32'(s_rd), 32'h0);
        check({tag, " s_wr"}, 32'(s_wr), 32'h0);
        check({tag, " s_addr"}, s_addr, 32'h0);
        check({tag, " s_wdata"}, s_wdata, 32'h0);
        check({tag, " waits"}, 32'({i_wait_req, dr_wait_req, dw_wait_req}), 32'h7);
    endtask

    initial begin
        // Reset with every master requesting.
        reset = 1'b0;
        i_addr = 32'h1111_0000; dr_addr = 32'h2222_0000;
        dw_addr = 32'h3333_0000; dw_data = 32'h4444_0000;
        i_rd = 1'b1; dr_rd = 1'b1; dw_wr = 1'b1;
        s_wait_req = 1'b0; s_rdata = 32'h0;
        #2;
        check_idle("reset");
        repeat (2) wait_edge;
        check_idle("reset_held");
        check("reset starve_cnt", 32'(dut.starve_cnt), 32'd0);
        @(negedge clk);
        i_rd = 1'b0; dr_rd = 1'b0; dw_wr = 1'b0;
        reset = 1'b1;

        // Single zero-wait instruction read.
        wait_edge;
        i_rd = 1'b1; i_addr = 32'h100; s_rdata = 32'hDEAD_BEEF; s_wait_req = 1'b0;
        @(negedge clk);
        check("rd pre-sample grant", 32'(grant), 32'h0);
        wait_edge;
        @(negedge clk);
        check("rd grant", 32'(grant), 32'h1);
        check("rd s_addr", s_addr, 32'h100);
        check("rd s_rd", 32'(s_rd), 32'h1);
        check("rd i_wait_req", 32'(i_wait_req), 32'h0);
        check("rd i_rdata", i_rdata, 32'hDEAD_BEEF);
        check("rd dr_rdata", dr_rdata, 32'hDEAD_BEEF);
        check("rd other waits", 32'({dr_wait_req, dw_wait_req}), 32'h3);
        check("rd starve_cnt", 32'(dut.starve_cnt), 32'd1);
        wait_edge;
        i_rd = 1'b0;
        @(negedge clk);
        check_idle("rd done");
        check("rd done starve_cnt", 32'(dut.starve_cnt), 32'd0);

        // All three request at once: DW, DR, I, each held until its completion.
        wait_edge;
        dw_wr = 1'b1; dw_addr = 32'h3000; dw_data = 32'hA5A5_0001;
        dr_rd = 1'b1; dr_addr = 32'h300;
        i_rd  = 1'b1; i_addr  = 32'h104;
        for (int k = 0; k < 6; k++) begin
            wait_edge;
            if (k == 1) dw_wr = 1'b0;
            if (k == 3) dr_rd = 1'b0;
            if (k == 5) i_rd  = 1'b0;
            @(negedge clk);
            check($sformatf("prio grant c%0d", k + 1), 32'(grant), 32'(prio_grant[k]));
            check($sformatf("prio s_addr c%0d", k + 1), s_addr, prio_addr[k]);
        end

        // Write stalled three cycles by the slave.
        wait_edge;
        dw_wr = 1'b1; dw_addr = 32'h2000; dw_data = 32'h1234_5678; s_wait_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_edge;
            if (k == 3) s_wait_req = 1'b0;
            @(negedge clk);
            check($sformatf("stall grant c%0d", k), 32'(grant), 32'h4);
            check($sformatf("stall s_wr c%0d", k), 32'(s_wr), 32'h1);
            check($sformatf("stall s_rd c%0d", k), 32'(s_rd), 32'h0);
            check($sformatf("stall s_addr c%0d", k), s_addr, 32'h2000);
            check($sformatf("stall s_wdata c%0d", k), s_wdata, 32'h1234_5678);
            check($sformatf("stall dw_wait c%0d", k), 32'(dw_wait_req), (k < 3) ? 32'h1 : 32'h0);
            check($sformatf("stall i/dr wait c%0d", k), 32'({i_wait_req, dr_wait_req}), 32'h3);
        end
        wait_edge;
        dw_wr = 1'b0;
        @(negedge clk);
        check_idle("stall done");

        // Data read withdrawn while stalled.
        wait_edge;
        dr_rd = 1'b1; dr_addr = 32'h500; s_wait_req = 1'b1;
        wait_edge;
        @(negedge clk);
        check("drop grant", 32'(grant), 32'h2);
        check("drop s_rd before", 32'(s_rd), 32'h1);
        dr_rd = 1'b0;
        #1;
        check("drop s_rd same cycle", 32'(s_rd), 32'h0);
        check("drop grant held", 32'(grant), 32'h2);
        wait_edge;
        @(negedge clk);
        check_idle("drop after");

        // Starvation boost with DW and DR hammering the bus.
        wait_edge;
        s_wait_req = 1'b0; s_rdata = 32'h0BAD_F00D;
        dw_wr = 1'b1; dw_addr = 32'h6000; dw_data = 32'h0000_0066;
        dr_rd = 1'b1; dr_addr = 32'h700;
        i_rd  = 1'b1; i_addr  = 32'h800;
        for (int k = 0; k < 10; k++) begin
            wait_edge;
            @(negedge clk);
            check($sformatf("starve grant c%0d", k + 1), 32'(grant), 32'(stv_grant[k]));
            check($sformatf("starve cnt c%0d", k + 1), 32'(dut.starve_cnt), stv_cnt[k]);
            if (k == 8) begin
                check("starve s_addr", s_addr, 32'h800);
                check("starve i_wait_req", 32'(i_wait_req), 32'h0);
                check("starve i_rdata", i_rdata, 32'h0BAD_F00D);
            end
        end
        dw_wr = 1'b0; dr_rd = 1'b0; i_rd = 1'b0;
        wait_edge;
        @(negedge clk);
        check_idle("starve end");

        // Reset lands in the middle of a stalled data read.
        wait_edge;
        dr_rd = 1'b1; dr_addr = 32'h400; s_wait_req = 1'b1; s_rdata = 32'hCAFE_F00D;
        wait_edge;
        @(negedge clk);
        check("rstmid grant", 32'(grant), 32'h2);
        check("rstmid s_rd", 32'(s_rd), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check_idle("rstmid async");
        wait_edge;
        check_idle("rstmid held");
        @(negedge clk);
        reset = 1'b1; s_wait_req = 1'b0;
        #1;
        check("rstmid release grant", 32'(grant), 32'h0);
        wait_edge;
        @(negedge clk);
        check("rstmid regrant", 32'(grant), 32'h2);
        check("rstmid s_addr", s_addr, 32'h400);
        check("rstmid s_rd again", 32'(s_rd), 32'h1);
        check("rstmid dr_wait", 32'(dr_wait_req), 32'h0);
        check("rstmid dr_rdata", dr_rdata, 32'hCAFE_F00D);
        wait_edge;
        dr_rd = 1'b0;
        @(negedge clk);
        check_idle("rstmid done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
